// File: rtl/mito_layer_sched_if.sv
// -----------------------------------------------------------------------------
// mito_layer_sched_if
// Bundles the host command, buffer strobe and pipeline handshake signals of
// the MITO per-layer sequencer.
//   master : host / datapath side (drives start, config, ifm_valid, ofm_ready)
//   slave  : sequencer side (drives read strobes, mode, status, ofm_valid)
// Optional: MITO_SCHED_PERF_EN adds perf_stall_cnt (sequencer -> host).
// -----------------------------------------------------------------------------
interface mito_layer_sched_if #(
  parameter int TILE_CNT_WIDTH = 16
) ();
  logic                      start;
  logic [1:0]                cfg_layer_type;
  logic [TILE_CNT_WIDTH-1:0] cfg_num_tiles;
  logic                      ifm_valid;
  logic                      ofm_ready;
  logic [2:0]                ifm_read;
  logic                      wgt_read;
  logic                      bias_read;
  logic [1:0]                mode;
  logic [1:0]                layer_type;
  logic                      ofm_valid;
  logic                      busy;
  logic                      done;
  logic                      cfg_err;
`ifdef MITO_SCHED_PERF_EN
  logic [31:0]               perf_stall_cnt;

  modport master (
    output start, cfg_layer_type, cfg_num_tiles, ifm_valid, ofm_ready,
    input  ifm_read, wgt_read, bias_read, mode, layer_type, ofm_valid,
           busy, done, cfg_err, perf_stall_cnt
  );
  modport slave (
    input  start, cfg_layer_type, cfg_num_tiles, ifm_valid, ofm_ready,
    output ifm_read, wgt_read, bias_read, mode, layer_type, ofm_valid,
           busy, done, cfg_err, perf_stall_cnt
  );
`else
  modport master (
    output start, cfg_layer_type, cfg_num_tiles, ifm_valid, ofm_ready,
    input  ifm_read, wgt_read, bias_read, mode, layer_type, ofm_valid,
           busy, done, cfg_err
  );
  modport slave (
    input  start, cfg_layer_type, cfg_num_tiles, ifm_valid, ofm_ready,
    output ifm_read, wgt_read, bias_read, mode, layer_type, ofm_valid,
           busy, done, cfg_err
  );
`endif
endinterface

// File: rtl/mito_layer_sched.sv
// -----------------------------------------------------------------------------
// mito_layer_sched
// Per-layer sequencer for the MITO datapath. A start pulse latches one layer
// descriptor; the block then strobes the bias and weight buffers, issues IFM
// beats under the ifm_valid/ofm_ready handshake, tracks beats in flight with a
// stallable delay line, drains it and pulses done.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts a layer, no done)
//   bus   : mito_layer_sched_if.slave (start/config/handshake in,
//           ifm_read/wgt_read/bias_read/mode/layer_type/ofm_valid/busy/
//           done/cfg_err out)
// Optional: MITO_SCHED_PERF_EN adds bus.perf_stall_cnt, a saturating count of
// COMPUTE/DRAIN stall cycles, cleared on each accepted start.
// Layer types: 0=CONV, 1=FC, 2=POOL, 3=reserved. PE_LATENCY must be >= 2 and
// >= POOL_LATENCY >= 1.
// -----------------------------------------------------------------------------
module mito_layer_sched #(
  parameter int WGT_LOAD_CYCLES = 9,
  parameter int PE_LATENCY      = 4,
  parameter int POOL_LATENCY    = 1,
  parameter int TILE_CNT_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mito_layer_sched_if.slave bus
);
  localparam int WGT_CNT_W = (WGT_LOAD_CYCLES > 32'sd1) ? $clog2(WGT_LOAD_CYCLES) : 32'sd1;
  // POOL beats are injected this far up the line so every result exits the last stage.
  localparam int POOL_INJ  = PE_LATENCY - POOL_LATENCY;

  localparam logic [1:0] TYPE_CONV = 2'd0;
  localparam logic [1:0] TYPE_POOL = 2'd2;
  localparam logic [1:0] TYPE_RSVD = 2'd3;

  localparam logic [TILE_CNT_WIDTH-1:0] TILE_ZERO = {TILE_CNT_WIDTH{1'b0}};
  localparam logic [TILE_CNT_WIDTH-1:0] TILE_ONE  = {{(TILE_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WGT_CNT_W-1:0]      WGT_ZERO  = {WGT_CNT_W{1'b0}};
  localparam logic [WGT_CNT_W-1:0]      WGT_ONE   = {{(WGT_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WGT_CNT_W-1:0]      WGT_LAST  = WGT_CNT_W'(WGT_LOAD_CYCLES - 32'sd1);
  localparam logic [PE_LATENCY-1:0]     DL_ZERO   = {PE_LATENCY{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BIAS    = 3'd1,
    ST_WGT     = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [1:0]                type_r;
  logic [TILE_CNT_WIDTH-1:0] beat_cnt_r;
  logic [WGT_CNT_W-1:0]      wgt_cnt_r;
  logic [2:0]                row_ptr_r;
  logic [PE_LATENCY-1:0]     dl_r;
  logic [PE_LATENCY-1:0]     dl_shift_s;
  logic                      bias_read_r;
  logic                      wgt_read_r;
  logic                      busy_r;
  logic                      done_r;
  logic                      cfg_err_r;
  logic                      start_acc_s;
  logic                      is_pool_s;
  logic                      accept_s;
  logic                      last_beat_s;
  logic                      dl_empty_next_s;

  assign start_acc_s = (state_r == ST_IDLE) && bus.start;
  assign is_pool_s   = (type_r == TYPE_POOL);
  assign accept_s    = (state_r == ST_COMPUTE) && (beat_cnt_r != TILE_ZERO)
                       && bus.ifm_valid && bus.ofm_ready;
  assign last_beat_s = accept_s && (beat_cnt_r == TILE_ONE);

  // Delay-line contents after one advance, with the accepted-beat strobe injected.
  always_comb begin
    dl_shift_s = {dl_r[PE_LATENCY-2:0], 1'b0};
    if (is_pool_s) begin
      dl_shift_s[POOL_INJ] = accept_s;
    end else begin
      dl_shift_s[0] = accept_s;
    end
  end

  // Looking one cycle ahead lets done land right after the last result transfer.
  assign dl_empty_next_s = bus.ofm_ready ? (dl_shift_s == DL_ZERO) : (dl_r == DL_ZERO);

  // Next-state decode for the layer sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!bus.start) begin
          state_nxt_s = ST_IDLE;
        end else if (bus.cfg_layer_type == TYPE_RSVD) begin
          state_nxt_s = ST_DONE;
        end else if (bus.cfg_layer_type == TYPE_POOL) begin
          state_nxt_s = (bus.cfg_num_tiles == TILE_ZERO) ? ST_DRAIN : ST_COMPUTE;
        end else begin
          state_nxt_s = ST_BIAS;
        end
      end
      ST_BIAS: state_nxt_s = ST_WGT;
      ST_WGT: begin
        if (wgt_cnt_r == WGT_ZERO) begin
          state_nxt_s = (beat_cnt_r == TILE_ZERO) ? ST_DRAIN : ST_COMPUTE;
        end else begin
          state_nxt_s = ST_WGT;
        end
      end
      ST_COMPUTE: begin
        if (last_beat_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_COMPUTE;
        end
      end
      ST_DRAIN: begin
        if (dl_empty_next_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Status and buffer strobes registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_read_r <= 1'b0;
      wgt_read_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      bias_read_r <= (state_nxt_s == ST_BIAS);
      wgt_read_r  <= (state_nxt_s == ST_WGT);
      busy_r      <= (state_nxt_s != ST_IDLE);
      done_r      <= (state_nxt_s == ST_DONE);
      cfg_err_r   <= start_acc_s && (bus.cfg_layer_type == TYPE_RSVD);
    end
  end

  // Layer descriptor latch, beat counter and CONV row pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_r     <= 2'd0;
      beat_cnt_r <= TILE_ZERO;
      row_ptr_r  <= 3'b001;
    end else if (start_acc_s) begin
      type_r     <= bus.cfg_layer_type;
      beat_cnt_r <= bus.cfg_num_tiles;
      row_ptr_r  <= 3'b001;
    end else if (accept_s) begin
      beat_cnt_r <= beat_cnt_r - TILE_ONE;
      if (type_r == TYPE_CONV) begin
        row_ptr_r <= {row_ptr_r[1:0], row_ptr_r[2]};
      end
    end
  end

  // Weight-load down-counter, loaded while in BIAS so WGT lasts exactly WGT_LOAD_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wgt_cnt_r <= WGT_ZERO;
    end else if (state_r == ST_BIAS) begin
      wgt_cnt_r <= WGT_LAST;
    end else if ((state_r == ST_WGT) && (wgt_cnt_r != WGT_ZERO)) begin
      wgt_cnt_r <= wgt_cnt_r - WGT_ONE;
    end
  end

  // In-flight tracking; frozen whenever the OFM buffer back-pressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_r <= DL_ZERO;
    end else if (bus.ofm_ready) begin
      dl_r <= dl_shift_s;
    end
  end

`ifdef MITO_SCHED_PERF_EN
  logic [31:0] perf_cnt_r;
  logic        stall_s;

  assign stall_s = ((state_r == ST_COMPUTE) || (state_r == ST_DRAIN))
                   && (!bus.ofm_ready || ((state_r == ST_COMPUTE) && !bus.ifm_valid));

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_r <= 32'd0;
    end else if (start_acc_s) begin
      perf_cnt_r <= 32'd0;
    end else if (stall_s && (perf_cnt_r != 32'hFFFF_FFFF)) begin
      perf_cnt_r <= perf_cnt_r + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = perf_cnt_r;
`endif

  // ifm_read is the only output gated by live inputs: strobes fire on accepted beats only.
  assign bus.ifm_read   = accept_s ? ((type_r == TYPE_CONV) ? row_ptr_r : 3'b111) : 3'b000;
  assign bus.wgt_read   = wgt_read_r;
  assign bus.bias_read  = bias_read_r;
  assign bus.mode       = type_r;
  assign bus.layer_type = type_r;
  assign bus.ofm_valid  = dl_r[PE_LATENCY-1];
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.cfg_err    = cfg_err_r;

endmodule

// File: tb/tb_mito_layer_sched.sv
// Testbench for mito_layer_sched: table of layer scenarios with a scoreboard of
// expected OFM transfer cycles, plus hand-written reset and start-on-DONE sequences.
module tb_mito_layer_sched;
  localparam int W      = 9;
  localparam int PE_L   = 4;
  localparam int POOL_L = 1;
  localparam int TW     = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mito_layer_sched_if #(.TILE_CNT_WIDTH(TW)) bus ();

  mito_layer_sched #(
    .WGT_LOAD_CYCLES(W),
    .PE_LATENCY(PE_L),
    .POOL_LATENCY(POOL_L),
    .TILE_CNT_WIDTH(TW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int cur_cyc  = 0;

  typedef struct {
    logic [1:0] ltype;
    int tiles;
    int stall_lo;   // ofm_ready low for cycles stall_lo..stall_hi (none if hi < lo)
    int stall_hi;
    int bubble;     // cycle with ifm_valid low (-1 = none)
    int exp_done;
    int exp_xfers;
    int exp_perf;
  } vec_t;

  vec_t vecs [7];
  int   sb_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cur_cyc, act, exp);
    end
  endtask

  function automatic bit rdy_at(input int c, input int lo, input int hi);
    return !((c >= lo) && (c <= hi));
  endfunction

  // Cycle in which a beat accepted at cycle b is transferred out: it needs lat-1
  // advances (ready cycles after b), becomes visible, then waits for ofm_ready.
  function automatic int xfer_cycle(input int b, input int lat, input int lo, input int hi);
    int c;
    int n;
    c = b;
    n = 0;
    while (n < lat - 1) begin
      c++;
      if (rdy_at(c, lo, hi)) n++;
    end
    c++;
    while (!rdy_at(c, lo, hi)) c++;
    return c;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_ifm_read"},   32'(bus.ifm_read),   32'd0);
    chk({tag, "_wgt_read"},   32'(bus.wgt_read),   32'd0);
    chk({tag, "_bias_read"},  32'(bus.bias_read),  32'd0);
    chk({tag, "_mode"},       32'(bus.mode),       32'd0);
    chk({tag, "_layer_type"}, 32'(bus.layer_type), 32'd0);
    chk({tag, "_ofm_valid"},  32'(bus.ofm_valid),  32'd0);
    chk({tag, "_busy"},       32'(bus.busy),       32'd0);
    chk({tag, "_done"},       32'(bus.done),       32'd0);
    chk({tag, "_cfg_err"},    32'(bus.cfg_err),    32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int cstart;
    int beats;
    int lat;
    int xfers;
    bit has_bias;
    bit rdy;
    bit vld;
    logic [2:0] row;
    logic [2:0] exp_ifm;
    has_bias = (v.ltype == 2'd0) || (v.ltype == 2'd1);
    cstart   = has_bias ? (W + 2) : 1;
    beats    = (v.ltype == 2'd3) ? 0 : v.tiles;
    lat      = (v.ltype == 2'd2) ? POOL_L : PE_L;
    row      = 3'b001;
    xfers    = 0;
    sb_q.delete();
    for (int c = 0; c <= v.exp_done + 2; c++) begin
      @(posedge clk); #1;
      cur_cyc = c;
      rdy = rdy_at(c, v.stall_lo, v.stall_hi);
      vld = (c != v.bubble);
      bus.start          = (c == 0);
      bus.cfg_layer_type = v.ltype;
      bus.cfg_num_tiles  = TW'(v.tiles);
      bus.ofm_ready      = rdy;
      bus.ifm_valid      = vld;
      @(negedge clk);
      exp_ifm = 3'b000;
      if ((c >= cstart) && (beats > 0) && rdy && vld) begin
        exp_ifm = (v.ltype == 2'd0) ? row : 3'b111;
        row     = {row[1:0], row[2]};
        beats--;
        sb_q.push_back(xfer_cycle(c, lat, v.stall_lo, v.stall_hi));
      end
      chk("ifm_read",  32'(bus.ifm_read),  32'(exp_ifm));
      chk("bias_read", 32'(bus.bias_read), 32'(has_bias && (c == 1)));
      chk("wgt_read",  32'(bus.wgt_read),  32'(has_bias && (c >= 2) && (c <= W + 1)));
      chk("done",      32'(bus.done),      32'(c == v.exp_done));
      chk("busy",      32'(bus.busy),      32'((c >= 1) && (c <= v.exp_done)));
      chk("cfg_err",   32'(bus.cfg_err),   32'((v.ltype == 2'd3) && (c == 1)));
      if (c >= 1) begin
        chk("layer_type", 32'(bus.layer_type), 32'(v.ltype));
        chk("mode",       32'(bus.mode),       32'(v.ltype));
      end
      if (bus.ofm_valid && rdy) begin
        xfers++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ofm_unexpected cycle=%0d actual=transfer expected=none", c);
        end else begin
          chk("ofm_xfer_cycle", 32'(c), 32'(sb_q.pop_front()));
        end
      end
    end
    chk("xfer_count", 32'(xfers), 32'(v.exp_xfers));
    chk("sb_pending", 32'(sb_q.size()), 32'd0);
`ifdef MITO_SCHED_PERF_EN
    chk("perf_stall_cnt", bus.perf_stall_cnt, 32'(v.exp_perf));
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cur_cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cyc;
    int xf;
    //          type   tiles lo  hi  bubble done xfers perf
    vecs[0] = '{2'd0, 3,    1,  0,  -1,    18,  3,    0};  // CONV baseline
    vecs[1] = '{2'd2, 2,    1,  0,  -1,    4,   2,    0};  // POOL
    vecs[2] = '{2'd0, 2,    12, 14, -1,    20,  2,    3};  // CONV, ofm_ready stall
    vecs[3] = '{2'd1, 0,    1,  0,  -1,    12,  0,    0};  // FC, zero tiles
    vecs[4] = '{2'd3, 5,    1,  0,  -1,    1,   0,    0};  // reserved type
    vecs[5] = '{2'd1, 4,    1,  0,  12,    20,  4,    1};  // FC, ifm_valid bubble
    vecs[6] = '{2'd2, 3,    4,  5,  -1,    7,   3,    2};  // POOL, stall in drain

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.cfg_layer_type = 2'd0;
    bus.cfg_num_tiles = '0;
    bus.ifm_valid = 1'b1;
    bus.ofm_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cur_cyc = -1;
    check_all_zero("reset");
`ifdef MITO_SCHED_PERF_EN
    chk("reset_perf", bus.perf_stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // start held through DONE is ignored there and accepted one cycle later in IDLE
    @(posedge clk); #1;
    cur_cyc = 0;
    bus.start = 1'b1; bus.cfg_layer_type = 2'd3; bus.cfg_num_tiles = 16'd1;
    bus.ifm_valid = 1'b1; bus.ofm_ready = 1'b1;
    @(posedge clk); #1;
    cur_cyc = 1;
    bus.cfg_layer_type = 2'd0;
    @(negedge clk);
    chk("seqA_done", 32'(bus.done), 32'd1);
    @(posedge clk); #1;
    cur_cyc = 2;
    @(negedge clk);
    chk("seqA_idle_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    cur_cyc = 3;
    bus.start = 1'b0;
    @(negedge clk);
    chk("seqA_bias", 32'(bus.bias_read), 32'd1);
    chk("seqA_layer_type", 32'(bus.layer_type), 32'd0);
    done_cyc = -1;
    xf = 0;
    for (int c = 4; c < 44 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      cur_cyc = c;
      @(negedge clk);
      if (bus.ofm_valid) xf++;
      if (bus.done) done_cyc = c;
    end
    chk("seqA_done_cycle", 32'(done_cyc), 32'd18);
    chk("seqA_xfers", 32'(xf), 32'd1);
    repeat (2) @(posedge clk);

    // reset while in WGT aborts; the next layer then runs with full timing
    @(posedge clk); #1;
    cur_cyc = 0;
    bus.start = 1'b1; bus.cfg_layer_type = 2'd0; bus.cfg_num_tiles = 16'd3;
    @(posedge clk); #1;
    cur_cyc = 1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    cur_cyc = 5;
    chk("seqB_in_wgt", 32'(bus.wgt_read), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("seqB_rst");
    @(posedge clk);
    @(negedge clk);
    check_all_zero("seqB_rst_hold");
    rst_n = 1'b1;
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mito_layer_sched.md
# mito_layer_sched

Per-layer sequencer for the MITO accelerator datapath. On a `start` pulse it latches one layer descriptor, drives the bias, weight and IFM buffer read strobes in order, and issues IFM beats under an input/output handshake. It tracks beats in flight through the PE array (or max-pooling path) with a stallable delay line, then drains the pipeline and pulses `done`. It sits between the host command interface and the IFM/WGT/BIAS buffers, the PE array, activation, max-pooling and OFM buffer.

## Interface
- `WGT_LOAD_CYCLES`, 9: cycles `wgt_read` is held per layer (one per PE column load).
- `PE_LATENCY`, 4: cycles from an accepted IFM beat to its result at the OFM buffer input (CONV/FC).
- `POOL_LATENCY`, 1: same, for the POOL path.
- `TILE_CNT_WIDTH`, 16: width of the beat counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: layer start pulse; sampled only in IDLE.
- `cfg_layer_type`  in  2: 0=CONV, 1=FC, 2=POOL, 3=reserved; latched at start.
- `cfg_num_tiles`  in  TILE_CNT_WIDTH: IFM beats to issue; latched at start.
- `ifm_valid`  in  1: IFM data is available for the current beat.
- `ofm_ready`  in  1: OFM buffer can accept a result; low stalls the pipeline.
- `ifm_read`  out  3: one-hot IFM row strobe; asserted only on accepted beats.
- `wgt_read`  out  1: weight buffer load strobe.
- `bias_read`  out  1: bias buffer load strobe.
- `mode`  out  2: datapath select, equal to the latched layer type (drives the pool/relu mux).
- `layer_type`  out  2: latched layer type, held until the next start.
- `ofm_valid`  out  1: result is valid at the OFM buffer input.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle completion pulse.
- `cfg_err`  out  1: one-cycle pulse when a reserved layer type is latched.

## Operation
- States: IDLE, BIAS, WGT, COMPUTE, DRAIN, DONE.
- IDLE: on `start`=1, latch the config and go to BIAS; for POOL go directly to COMPUTE; for reserved type pulse `cfg_err` and go to DONE. `start` is ignored in all other states.
- BIAS: exactly 1 cycle with `bias_read`=1, then WGT.
- WGT: `wgt_read`=1 for exactly WGT_LOAD_CYCLES cycles, with a down-counter; then COMPUTE.
- COMPUTE:
  - A beat is accepted when `ifm_valid && ofm_ready`.
  - On each accepted beat, `ifm_read` is driven and the beat counter decrements.
  - CONV: the row pointer rotates 001→010→100→001 per accepted beat and resets to 001 at each start.
  - FC and POOL: `ifm_read`=111 on each accepted beat.
  - Leave for DRAIN in the cycle after the last beat is accepted.
  - `cfg_num_tiles`=0: skip COMPUTE entirely and go to DRAIN.
- Delay line:
  - Depth is PE_LATENCY, or POOL_LATENCY when the latched type is POOL.
  - Input is the accepted-beat strobe; the line shifts only when `ofm_ready`=1.
  - `ofm_valid` is the last stage; a transfer occurs on `ofm_valid && ofm_ready`.
- DRAIN: stay until the delay line is all zero, then DONE.
- DONE: `done`=1 for 1 cycle, then IDLE. `layer_type` and `mode` hold their values.

## Timing
- Reset (async assert) values:
  - State IDLE.
  - Outputs 0: `ifm_read`, `wgt_read`, `bias_read`, `mode`, `layer_type`, `ofm_valid`, `busy`, `done`, `cfg_err`.
  - Delay line cleared; counters 0; row pointer 001.
- Reset mid-layer aborts immediately. No `done` is generated and in-flight results are discarded.
- All outputs are registered, or decoded from registered state/counters with no input-to-output combinational path. The one exception is `ifm_read`, which is the registered row pointer gated by the accept condition.
- Latency, start at cycle 0 with `ifm_valid`=`ofm_ready`=1:
  - BIAS at cycle 1; WGT at cycles 2..1+WGT_LOAD_CYCLES.
  - First beat at 2+WGT_LOAD_CYCLES.
  - Each result appears PE_LATENCY cycles after its beat.
  - `done` asserts the cycle after the last result transfer.
- `ofm_ready`=0 freezes the delay line, `ofm_valid`, beat issue and the row pointer. `ifm_valid`=0 inserts a bubble in the delay line.
- `start` arriving on the same cycle as DONE is ignored; it is accepted from IDLE one cycle later.

## Configuration
- `MITO_SCHED_PERF_EN` defined:
  - Adds output `perf_stall_cnt` (32 bits, reset 0).
  - Cleared at each accepted start.
  - Increments on every COMPUTE or DRAIN cycle with `ofm_ready`=0 or (COMPUTE and `ifm_valid`=0); saturates at all-ones.
- `MITO_SCHED_PERF_EN` undefined: the port and counter do not exist; all other behaviour is identical.

## Test plan
- CONV, 3 tiles, defaults, no stalls, start at cycle 0:
  - `bias_read` at cycle 1; `wgt_read` at cycles 2–10.
  - `ifm_read` 001/010/100 at cycles 11–13.
  - `ofm_valid` at cycles 15–17; `done` at cycle 18; `busy` low at cycle 19.
- POOL, 2 tiles, start at cycle 0: no `bias_read`/`wgt_read`; `ifm_read`=111 at cycles 1–2; `ofm_valid` at cycles 2–3; `done` at cycle 4.
- CONV, 2 tiles, `ofm_ready`=0 for cycles 12–14: `ofm_valid` pattern is shifted by exactly 3 cycles, no beat is lost, exactly 2 transfers occur; with PERF_EN, `perf_stall_cnt`=3.
- `cfg_num_tiles`=0, FC: BIAS and WGT run, zero `ofm_valid`, `done` at cycle 12.
- `cfg_layer_type`=3: `cfg_err` and `done` pulse once each, and no read strobes assert.
- Reset asserted in WGT, then start again: all outputs are 0 during reset and the new layer runs the full CONV timing from scratch.
